// File: rtl/pipe_rr_arbiter_if.sv
// Handshake bundle between N requesters, the round-robin arbiter and the
// shared downstream pipeline stage.
interface pipe_rr_arbiter_if #(
   parameter int WIDTH = 100,
   parameter int N     = 4,
   parameter int IDW   = 2
);
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_allowin;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [IDW-1:0]     out_id;
   logic               out_last;
   logic               out_allowin;

   // Requester/pipeline side: drives beats in, consumes the output stage
   modport master (
      output in_valid, in_data, in_last, out_allowin,
      input  in_allowin, out_valid, out_data, out_id, out_last
   );

   // Arbiter side
   modport slave (
      input  in_valid, in_data, in_last, out_allowin,
      output in_allowin, out_valid, out_data, out_id, out_last
   );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding one registered output stage. Multi-beat
// packets lock the grant to their owner until the last beat transfers.
module pipe_rr_arbiter #(
   parameter int WIDTH = 100,
   parameter int N     = 4,
   parameter int IDW   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_rr_arbiter_if.slave    bus
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   owner_q;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [IDW-1:0]   out_id_q,    out_id_d;
   logic             out_last_q,  out_last_d;

   logic             stage_allowin;
   logic             gnt_vld;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   scan_idx;
   logic [IDW-1:0]   nxt_idx;
   logic             xfer;
   logic [WIDTH-1:0] data_sel;
   logic             last_sel;
   logic [N-1:0]     allow;

   // Output stage can take a new beat when empty or draining this cycle
   assign stage_allowin = !out_valid_q || bus.out_allowin;

   // Grant: locked owner only, or first valid requester scanning from ptr
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      if (state_q == LOCK) begin
         gnt_idx = owner_q;
         gnt_vld = bus.in_valid[owner_q];
      end else begin
         // Scan backwards so the requester closest to ptr is written last
         for (int k = N - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(ptr_q) + k) % N);
            if (bus.in_valid[scan_idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = scan_idx;
            end
         end
      end
   end

   // Reset gating keeps every accept low while rst_n is asserted
   assign xfer    = gnt_vld && stage_allowin && rst_n;
   assign nxt_idx = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;

   // Select the granted beat and build the one-hot accept vector
   always_comb begin
      data_sel = '0;
      last_sel = 1'b0;
      allow    = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == IDW'(i)) begin
            data_sel = bus.in_data[i*WIDTH +: WIDTH];
            last_sel = bus.in_last[i];
            allow[i] = xfer;
         end
      end
   end

   // Output stage next state: load, drain to empty, or hold under stall
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      out_last_d  = out_last_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = data_sel;
         out_id_d    = gnt_idx;
         out_last_d  = last_sel;
      end else if (bus.out_allowin) begin
         out_valid_d = 1'b0;
      end
   end

   // Output stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         out_last_q  <= out_last_d;
      end
   end

   // Lock FSM and round-robin pointer; only a transferred beat moves them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
      end else if (xfer) begin
         case (state_q)
            IDLE: begin
               if (last_sel) begin
                  ptr_q <= nxt_idx;
               end else begin
                  state_q <= LOCK;
                  owner_q <= gnt_idx;
               end
            end
            LOCK: begin
               if (last_sel) begin
                  state_q <= IDLE;
                  ptr_q   <= nxt_idx;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_allowin = allow;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_id     = out_id_q;
   assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter: per-requester beat queues drive the
// inputs, an expected-output queue is checked whenever a beat leaves.
module tb_pipe_rr_arbiter;

   localparam int W   = 100;
   localparam int N   = 4;
   localparam int IDW = 2;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
      int           gap;
   } beat_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   d;
      logic           l;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pipe_rr_arbiter_if #(.WIDTH(W), .N(N), .IDW(IDW)) bus ();

   pipe_rr_arbiter #(.WIDTH(W), .N(N), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   beat_t        rq [N][$];
   bit           started [N];
   exp_t         exp_q [$];
   logic [N-1:0] acc;
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic add(input int r, input logic [W-1:0] d, input logic l, input int gap);
      beat_t b;
      b.d = d; b.l = l; b.gap = gap;
      rq[r].push_back(b);
   endtask

   task automatic expect_beat(input int id, input logic [W-1:0] d, input logic l);
      exp_t e;
      e.id = IDW'(id); e.d = d; e.l = l;
      exp_q.push_back(e);
   endtask

   // Retire accepted beats, then present the next beat of each requester
   task automatic drive();
      logic [N-1:0]   v;
      logic [N*W-1:0] dat;
      logic [N-1:0]   lst;
      beat_t          b;
      v = '0; dat = '0; lst = '0;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            rq[i].delete(0);
            started[i] = 1'b0;
         end
         if (rq[i].size() > 0) begin
            b = rq[i][0];
            if (!started[i]) begin
               if (b.gap > 0) begin
                  b.gap--;
                  rq[i][0] = b;
               end else begin
                  started[i] = 1'b1;
               end
            end
            if (started[i]) begin
               v[i] = 1'b1;
               dat[i*W +: W] = b.d;
               lst[i] = b.l;
            end
         end
      end
      acc = '0;
      bus.in_valid = v;
      bus.in_data  = dat;
      bus.in_last  = lst;
   endtask

   // Mid-cycle sample: record accepts and check any beat leaving the stage
   task automatic sample();
      exp_t e;
      @(negedge clk);
      acc = bus.in_valid & bus.in_allowin;
      chk("allowin_onehot0", 128'($onehot0(bus.in_allowin)), 128'd1);
      if (bus.out_valid && bus.out_allowin) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 128'(bus.out_valid), 128'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_id",   128'(bus.out_id),   128'(e.id));
            chk("out_data", 128'(bus.out_data), 128'(e.d));
            chk("out_last", 128'(bus.out_last), 128'(e.l));
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk("drain_pending", 128'(exp_q.size()), 128'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      acc = '0;
      bus.out_allowin = 1'b1;
      for (int i = 0; i < N; i++) started[i] = 1'b0;

      // Reset with every requester valid; two single-beat packets each
      for (int r = 0; r < N; r++) begin
         add(r, W'(16'h1000 + r), 1'b1, 0);
         add(r, W'(16'h2000 + r), 1'b1, 0);
      end
      for (int r = 0; r < N; r++) expect_beat(r, W'(16'h1000 + r), 1'b1);
      for (int r = 0; r < N; r++) expect_beat(r, W'(16'h2000 + r), 1'b1);
      drive();
      sample();
      chk("rst_allowin",   128'(bus.in_allowin), 128'd0);
      chk("rst_out_valid", 128'(bus.out_valid),  128'd0);
      chk("rst_out_id",    128'(bus.out_id),     128'd0);
      chk("rst_out_data",  128'(bus.out_data),   128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sample();
      chk("first_grant", 128'(bus.in_allowin), 128'b0001);
      advance();
      // Fairness: 0,1,2,3,0,1,2,3 with no bubble
      for (int c = 0; c < 2 * N; c++) begin
         sample();
         chk("rr_no_bubble", 128'(bus.out_valid), 128'd1);
         advance();
      end
      drain(10);

      // Lock: requester 2 sends 3 beats while 0 and 3 wait; 1 moves ptr to 2
      add(1, W'(16'h3100), 1'b1, 0);
      add(2, W'(16'h3200), 1'b0, 1);
      add(2, W'(16'h3201), 1'b0, 0);
      add(2, W'(16'h3202), 1'b1, 0);
      add(0, W'(16'h3000), 1'b1, 1);
      add(3, W'(16'h3300), 1'b1, 1);
      expect_beat(1, W'(16'h3100), 1'b1);
      expect_beat(2, W'(16'h3200), 1'b0);
      expect_beat(2, W'(16'h3201), 1'b0);
      expect_beat(2, W'(16'h3202), 1'b1);
      expect_beat(3, W'(16'h3300), 1'b1);
      expect_beat(0, W'(16'h3000), 1'b1);
      drive();
      drain(20);

      // Backpressure: 0xA5 parked in the output stage for 5 cycles
      add(1, W'(8'hA5), 1'b1, 0);
      add(2, W'(8'h5A), 1'b1, 0);
      expect_beat(1, W'(8'hA5), 1'b1);
      expect_beat(2, W'(8'h5A), 1'b1);
      drive();
      sample();
      chk("bp_first_grant", 128'(bus.in_allowin), 128'b0010);
      bus.out_allowin = 1'b0;
      advance();
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("bp_out_valid", 128'(bus.out_valid),  128'd1);
         chk("bp_out_data",  128'(bus.out_data),   128'hA5);
         chk("bp_allowin",   128'(bus.in_allowin), 128'd0);
         advance();
      end
      bus.out_allowin = 1'b1;
      drain(20);

      // Owner bubble: requester 1 drops valid for 2 cycles inside its packet
      add(1, W'(16'h5100), 1'b0, 0);
      add(1, W'(16'h5101), 1'b0, 2);
      add(1, W'(16'h5102), 1'b1, 0);
      add(0, W'(16'h5000), 1'b1, 1);
      add(3, W'(16'h5300), 1'b1, 3);
      expect_beat(1, W'(16'h5100), 1'b0);
      expect_beat(1, W'(16'h5101), 1'b0);
      expect_beat(1, W'(16'h5102), 1'b1);
      expect_beat(3, W'(16'h5300), 1'b1);
      expect_beat(0, W'(16'h5000), 1'b1);
      drive();
      tick();
      sample();
      chk("bubble_allowin", 128'(bus.in_allowin), 128'd0);
      advance();
      drain(20);

      // Async reset while requester 3 owns the lock
      add(3, W'(16'h7300), 1'b0, 0);
      add(3, W'(16'h7301), 1'b0, 0);
      expect_beat(3, W'(16'h7300), 1'b0);
      drive();
      sample();
      chk("lock3_grant", 128'(bus.in_allowin), 128'b1000);
      advance();
      sample();
      chk("lock3_out_valid", 128'(bus.out_valid), 128'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 128'(bus.out_valid),  128'd0);
      chk("arst_allowin",   128'(bus.in_allowin), 128'd0);
      chk("arst_out_id",    128'(bus.out_id),     128'd0);
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         started[i] = 1'b0;
      end
      acc = '0;
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      add(1, W'(16'h8100), 1'b1, 0);
      add(2, W'(16'h8200), 1'b1, 0);
      add(0, W'(16'h8000), 1'b1, 0);
      expect_beat(0, W'(16'h8000), 1'b1);
      expect_beat(1, W'(16'h8100), 1'b1);
      expect_beat(2, W'(16'h8200), 1'b1);
      drive();
      sample();
      chk("post_rst_grant", 128'(bus.in_allowin), 128'b0001);
      advance();
      drain(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
